// File: rtl/memory_access.sv
// memory_access: execute->writeback stage of the swt16 core; issues data-memory
//   loads/stores over req/ack and registers the writeback triple.
// Latency: 1 cycle for ALU results; load result 1 cycle after dmem_ack.
// Backpressure: out_stall is high for every WAIT cycle; upstream holds in_* stable.
//
// Ports:
//   clock, reset (async, active-high)
//   in_valid, in_op_load, in_op_store, in_act_write_res_to_reg, in_res,
//   in_store_data, in_res_reg_idx      : instruction from execute
//   out_stall                          : combinational decode of WAIT state
//   dmem_req/we/addr/wdata             : registered memory request
//   dmem_ack, dmem_rdata               : memory completion and read data
//   out_act_write_res_to_reg, out_res,
//   out_res_reg_idx                    : registered writeback triple
//   out_err                            : one-cycle timeout pulse
// Optional feature: define MEMORY_ACCESS_TIMEOUT_EN to enable the WAIT watchdog
//   (TIMEOUT_CYCLES); otherwise WAIT lasts until ack and out_err is tied to 0.
module memory_access #(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_WORD_WIDTH = 16,
  parameter int IALU_WORD_WIDTH = 16,
  parameter int REG_IDX_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES  = 15
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic                       in_op_load,
  input  logic                       in_op_store,
  input  logic                       in_act_write_res_to_reg,
  input  logic [IALU_WORD_WIDTH-1:0] in_res,
  input  logic [DMEM_WORD_WIDTH-1:0] in_store_data,
  input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
  output logic                       out_stall,
  output logic                       dmem_req,
  output logic                       dmem_we,
  output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [DMEM_WORD_WIDTH-1:0] dmem_wdata,
  input  logic                       dmem_ack,
  input  logic [DMEM_WORD_WIDTH-1:0] dmem_rdata,
  output logic                       out_act_write_res_to_reg,
  output logic [IALU_WORD_WIDTH-1:0] out_res,
  output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
  output logic                       out_err
);

  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;

  state_t                     r_state, w_state_nxt;
  logic                       r_req, w_req_nxt;
  logic                       r_we, w_we_nxt;
  logic [DMEM_ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [DMEM_WORD_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic                       r_act, w_act_nxt;
  logic [IALU_WORD_WIDTH-1:0] r_res, w_res_nxt;
  logic [REG_IDX_WIDTH-1:0]   r_idx, w_idx_nxt;
  logic [REG_IDX_WIDTH-1:0]   r_ld_idx, w_ld_idx_nxt;
  logic                       r_is_load, w_is_load_nxt;
  logic                       w_mem_op;

  // Only the low address bits reach the memory.
  logic [IALU_WORD_WIDTH-DMEM_ADDR_WIDTH-1:0] w_unused_res_hi;
  assign w_unused_res_hi = in_res[IALU_WORD_WIDTH-1:DMEM_ADDR_WIDTH];

  assign w_mem_op = in_op_load | in_op_store;

`ifdef MEMORY_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err, w_err_nxt;
  logic             w_expire;

  // r_cnt counts completed WAIT cycles; it is 0 in the first WAIT cycle,
  // so expiry in cycle TIMEOUT_CYCLES of WAIT sees TIMEOUT_CYCLES-1.
  assign w_expire = (r_state == S_WAIT) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_nxt;
      if (r_state == S_WAIT) r_cnt <= r_cnt + CNT_W'(1);
      else                   r_cnt <= '0;
    end
  end
  assign out_err = r_err;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign out_err = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_act     <= 1'b0;
      r_res     <= '0;
      r_idx     <= '0;
      r_ld_idx  <= '0;
      r_is_load <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_req     <= w_req_nxt;
      r_we      <= w_we_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_act     <= w_act_nxt;
      r_res     <= w_res_nxt;
      r_idx     <= w_idx_nxt;
      r_ld_idx  <= w_ld_idx_nxt;
      r_is_load <= w_is_load_nxt;
    end
  end

  // Next-state and next-output decode. The writeback triple defaults to a
  // bubble; the request fields hold their values unless explicitly changed.
  always_comb begin
    w_state_nxt   = r_state;
    w_req_nxt     = r_req;
    w_we_nxt      = r_we;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_act_nxt     = 1'b0;
    w_res_nxt     = '0;
    w_idx_nxt     = '0;
    w_ld_idx_nxt  = r_ld_idx;
    w_is_load_nxt = r_is_load;
`ifdef MEMORY_ACCESS_TIMEOUT_EN
    w_err_nxt     = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (w_mem_op) begin
            w_req_nxt     = 1'b1;
            w_we_nxt      = in_op_store;
            w_addr_nxt    = in_res[DMEM_ADDR_WIDTH-1:0];
            w_wdata_nxt   = in_store_data;
            w_ld_idx_nxt  = in_res_reg_idx;
            // load+store together behaves as a store: no register write
            w_is_load_nxt = in_op_load & ~in_op_store;
            w_state_nxt   = S_WAIT;
          end else begin
            w_act_nxt = in_act_write_res_to_reg;
            w_res_nxt = in_res;
            w_idx_nxt = in_res_reg_idx;
          end
        end
      end
      S_WAIT: begin
        // ack is checked first so it wins over a simultaneous timeout
        if (dmem_ack) begin
          w_req_nxt   = 1'b0;
          w_we_nxt    = 1'b0;
          w_state_nxt = S_IDLE;
          if (r_is_load) begin
            w_act_nxt = 1'b1;
            w_res_nxt = dmem_rdata;
            w_idx_nxt = r_ld_idx;
          end
        end
`ifdef MEMORY_ACCESS_TIMEOUT_EN
        else if (w_expire) begin
          w_req_nxt   = 1'b0;
          w_we_nxt    = 1'b0;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign out_stall                = (r_state == S_WAIT);
  assign dmem_req                 = r_req;
  assign dmem_we                  = r_we;
  assign dmem_addr                = r_addr;
  assign dmem_wdata               = r_wdata;
  assign out_act_write_res_to_reg = r_act;
  assign out_res                  = r_res;
  assign out_res_reg_idx          = r_idx;

endmodule
